ex_forward_ctrl: RTL
====================

# ex_forward_ctrl

Operand-forwarding and load-use hazard controller for the Execute stage. It tracks the destination registers of the instructions in EX, MEM and WB. It computes registered 2-bit select codes for the two Execute operand source muxes (A and B). It also stalls IF/ID and injects a one-cycle bubble when a load result cannot be forwarded in time.

## Interface
Parameters:
- REG_W, 5, register-specifier width
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pipe_hold  in  1  global freeze (memory busy); all state holds
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_W  source register A of ID instruction
- id_rt  in  REG_W  source register B of ID instruction
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_dst  in  REG_W  destination register of ID instruction
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_bubble  out  1  registered; EX holds an injected NOP
- ex_fwd_a  out  2  registered; operand A select: 00 regfile, 01 MEM-stage ALU result, 10 WB-stage write data
- ex_fwd_b  out  2  registered; same encoding for operand B
- stall_count  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Shadow pipeline: ex_{dst,rw,mr}, mem_{dst,rw}, wb_{dst,rw}. A destination is "live" only if rw=1 and dst≠0; register 0 never forwards or stalls.
- Load-use hazard (combinational): id_valid & ex_mr & ex_rw & ex_dst≠0 & ((id_use_rs & id_rs==ex_dst) | (id_use_rt & id_rt==ex_dst)). stall = hazard & ~pipe_hold.
- Advance on each rising edge when pipe_hold=0:
  - wb ← mem
  - mem ← ex
  - If hazard: ex ← {0,0,0}, ex_bubble←1, ex_fwd_a/b←00.
  - Else: ex ← {id_dst, id_regwrite&id_valid, id_memread&id_valid}, ex_bubble←~id_valid.
- Select computation (evaluated at ID, registered into EX), per operand X∈{rs,rt} with its use flag:
  - 01 if the current ex entry is live and ex_dst==X. That instruction will be in MEM next cycle.
  - Else 10 if the current mem entry is live and mem_dst==X. That instruction will be in WB next cycle.
  - Else 00.
  - Use flag 0 → 00. MEM priority over WB is mandatory (youngest wins).
- The 01 case never coincides with a load in ex, because that case is the hazard and produces a bubble instead.
- After a stall cycle, the load has moved to mem. The re-presented consumer then gets 10 (WB forward).
- pipe_hold=1: every register, including stall_count, holds; stall=0.
- stall_count increments once per cycle with stall=1 and saturates at all-ones.

## Timing
- Reset values (asynchronous, immediate): all shadow entries {0,0,0}, ex_fwd_a=ex_fwd_b=00, ex_bubble=1, stall_count=0. stall is 0 because ex_mr=0.
- stall has zero latency, combinational from the id_* inputs and the ex shadow registers.
- ex_fwd_a/b and ex_bubble: one cycle latency. They are valid for the whole cycle the instruction occupies EX.
- A load-use hazard costs exactly one stall cycle. Back-to-back loads feeding each other cost one stall each.
- Reset asserted mid-stall clears the stall in the same cycle. No partial state survives.
- Simultaneous pipe_hold and hazard: hold wins. No bubble is inserted and the counter does not move. The hazard is re-evaluated after hold drops.

## Test plan
- Reset: drive rst=1 mid-stream → outputs 00/00, ex_bubble=1, stall=0, stall_count=0 immediately. After release, the first id_valid instruction gives ex_bubble=0.
- EX-to-EX forward: issue `add $3,$1,$2` then `sub $4,$3,$3` → second instruction in EX shows ex_fwd_a=01, ex_fwd_b=01, stall never high.
- WB forward and priority:
  - `add $5`, NOP, `or $6,$5,$0` → ex_fwd_a=10, ex_fwd_b=00.
  - `add $5`, `addi $5`, `or $6,$5,$0` → ex_fwd_a=01, because MEM is youngest.
- Load-use: `lw $7,0($1)` then `add $8,$7,$2` → stall=1 for exactly one cycle, ex_bubble=1 next cycle. The add then enters EX with ex_fwd_a=10, and stall_count=1.
- Register zero and use flags:
  - `lw $0` followed by a reader of $0 → no stall, selects 00.
  - `lw $9` followed by an I-type with id_use_rt=0 and id_rt=9 → no stall.
- Hold: assert pipe_hold during a pending load-use hazard for 3 cycles → stall=0 and all outputs and the counter frozen. After release, stall=1 for one cycle.

Source files
------------

// File: rtl/ex_forward_ctrl_if.sv
// ID-stage request bundle and Execute-stage forwarding/stall responses.
// The master drives the ID instruction fields; the slave returns the selects.
interface ex_forward_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic             pipe_hold;
   logic             id_valid;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic [REG_W-1:0] id_dst;
   logic             id_regwrite;
   logic             id_memread;
   logic             stall;
   logic             ex_bubble;
   logic [1:0]       ex_fwd_a;
   logic [1:0]       ex_fwd_b;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output pipe_hold, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_dst, id_regwrite, id_memread,
      input  stall, ex_bubble, ex_fwd_a, ex_fwd_b, stall_count
   );

   modport slave (
      input  pipe_hold, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_dst, id_regwrite, id_memread,
      output stall, ex_bubble, ex_fwd_a, ex_fwd_b, stall_count
   );
endinterface

// File: rtl/ex_forward_ctrl.sv
// Execute-stage operand forwarding and load-use hazard control.
// Tracks EX/MEM/WB destinations and registers the operand mux selects into EX.
module ex_forward_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   ex_forward_ctrl_if.slave bus
);
   logic [REG_W-1:0] ex_dst, mem_dst, wb_dst;
   logic             ex_rw, ex_mr, mem_rw, wb_rw;
   logic             ex_live, mem_live, hazard;
   logic [1:0]       sel_a, sel_b;
   logic             unused_wb;

   // WB entry exists to complete the shadow pipeline; nothing downstream reads it.
   assign unused_wb = ^{wb_dst, wb_rw};

   assign ex_live  = ex_rw  && (ex_dst  != '0);
   assign mem_live = mem_rw && (mem_dst != '0);

   assign hazard = bus.id_valid && ex_mr && ex_live &&
                   ((bus.id_use_rs && (bus.id_rs == ex_dst)) ||
                    (bus.id_use_rt && (bus.id_rt == ex_dst)));

   assign bus.stall = hazard && !bus.pipe_hold;

   always_comb begin
      sel_a = 2'b00;
      if (bus.id_use_rs) begin
         if (ex_live && (ex_dst == bus.id_rs))
            sel_a = 2'b01;
         else if (mem_live && (mem_dst == bus.id_rs))
            sel_a = 2'b10;
      end
   end

   always_comb begin
      sel_b = 2'b00;
      if (bus.id_use_rt) begin
         if (ex_live && (ex_dst == bus.id_rt))
            sel_b = 2'b01;
         else if (mem_live && (mem_dst == bus.id_rt))
            sel_b = 2'b10;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_dst          <= '0;
         ex_rw           <= 1'b0;
         ex_mr           <= 1'b0;
         mem_dst         <= '0;
         mem_rw          <= 1'b0;
         wb_dst          <= '0;
         wb_rw           <= 1'b0;
         bus.ex_bubble   <= 1'b1;
         bus.ex_fwd_a    <= 2'b00;
         bus.ex_fwd_b    <= 2'b00;
         bus.stall_count <= '0;
      end else if (!bus.pipe_hold) begin
         wb_dst  <= mem_dst;
         wb_rw   <= mem_rw;
         mem_dst <= ex_dst;
         mem_rw  <= ex_rw;
         if (hazard) begin
            ex_dst        <= '0;
            ex_rw         <= 1'b0;
            ex_mr         <= 1'b0;
            bus.ex_bubble <= 1'b1;
            bus.ex_fwd_a  <= 2'b00;
            bus.ex_fwd_b  <= 2'b00;
            if (bus.stall_count != '1)
               bus.stall_count <= bus.stall_count + CNT_W'(1);
         end else begin
            ex_dst        <= bus.id_dst;
            ex_rw         <= bus.id_regwrite && bus.id_valid;
            ex_mr         <= bus.id_memread && bus.id_valid;
            bus.ex_bubble <= !bus.id_valid;
            bus.ex_fwd_a  <= sel_a;
            bus.ex_fwd_b  <= sel_b;
         end
      end
   end
endmodule
